// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter, its two requesters and the byte-wide RAM/IO bus.
// The arbiter takes the master modport; the requesters/RAM environment take slave.
interface mem_arbiter_if;
    logic        rdy;
    logic        clr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    logic        IF_S;
    logic [31:0] IF_pc;
    logic        IF_success;
    logic [31:0] IF_value;

    logic        LSB_S;
    logic        LSB_op;
    logic [31:0] LSB_pc;
    logic [2:0]  LSB_len;
    logic [31:0] LSB_data;
    logic        LSB_success;
    logic [31:0] LSB_value;

    modport master (
        input  rdy, clr, mem_din, io_buffer_full,
        input  IF_S, IF_pc,
        input  LSB_S, LSB_op, LSB_pc, LSB_len, LSB_data,
        output mem_dout, mem_a, mem_wr,
        output IF_success, IF_value,
        output LSB_success, LSB_value
    );

    modport slave (
        output rdy, clr, mem_din, io_buffer_full,
        output IF_S, IF_pc,
        output LSB_S, LSB_op, LSB_pc, LSB_len, LSB_data,
        input  mem_dout, mem_a, mem_wr,
        input  IF_success, IF_value,
        input  LSB_success, LSB_value
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter of instruction fetch and load/store buffer onto a byte-wide RAM/IO bus,
// splitting each grant into 1-4 single-byte cycles and assembling little-endian read data.
//
// state | meaning
// IDLE  | sample requests, grant and issue the first byte on the same edge
// READ  | issue read addresses, capture returned bytes one edge later
// WRITE | issue write bytes, stalling on a full IO sink
// DONE  | one-cycle success pulse; stale requests ignored
module mem_arbiter #(
    parameter logic [31:0] IO_BASE = 32'h30000
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic PORT_IF  = 1'b0;
    localparam logic PORT_LSB = 1'b1;

    state_t      state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [2:0]  n_q, n_d;
    logic [2:0]  ic_q, ic_d;
    logic [2:0]  rc_q, rc_d;
    logic        a_vld_q, a_vld_d;
    logic [31:0] buf_q, buf_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic        wr_op_q, wr_op_d;
    logic [31:0] data_q, data_d;

    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;
    logic        if_success_q, if_success_d;
    logic [31:0] if_value_q, if_value_d;
    logic        lsb_success_q, lsb_success_d;
    logic [31:0] lsb_value_q, lsb_value_d;

    logic        sel_lsb;
    logic        do_issue;
    logic        io_stall;
    logic [7:0]  wr_byte;

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        n_d           = n_q;
        ic_d          = ic_q;
        rc_d          = rc_q;
        a_vld_d       = 1'b0;
        buf_d         = buf_q;
        owner_d       = owner_q;
        last_d        = last_q;
        wr_op_d       = wr_op_q;
        data_d        = data_q;
        mem_a_d       = mem_a_q;
        mem_dout_d    = mem_dout_q;
        mem_wr_d      = 1'b0;
        if_success_d  = 1'b0;
        if_value_d    = if_value_q;
        lsb_success_d = 1'b0;
        lsb_value_d   = lsb_value_q;
        sel_lsb       = 1'b0;
        do_issue      = 1'b0;
        io_stall      = 1'b0;
        wr_byte       = 8'h00;

        case (state_q)
            IDLE: begin
                if (bus.rdy && (bus.IF_S || bus.LSB_S)) begin
                    // On a tie the port that did not win last time gets the bus.
                    sel_lsb  = bus.LSB_S && (!bus.IF_S || last_q == PORT_IF);
                    owner_d  = sel_lsb ? PORT_LSB : PORT_IF;
                    last_d   = owner_d;
                    base_d   = sel_lsb ? bus.LSB_pc : bus.IF_pc;
                    n_d      = sel_lsb ? bus.LSB_len : 3'd4;
                    wr_op_d  = sel_lsb && bus.LSB_op;
                    data_d   = bus.LSB_data;
                    ic_d     = 3'd0;
                    rc_d     = 3'd0;
                    buf_d    = 32'h0;
                    state_d  = wr_op_d ? WRITE : READ;
                    do_issue = 1'b1;
                end
            end

            READ: begin
                // The byte for last edge's address is captured even while rdy is low.
                if (a_vld_q) begin
                    case (rc_q[1:0])
                        2'd0:    buf_d[7:0]   = bus.mem_din;
                        2'd1:    buf_d[15:8]  = bus.mem_din;
                        2'd2:    buf_d[23:16] = bus.mem_din;
                        default: buf_d[31:24] = bus.mem_din;
                    endcase
                    rc_d = rc_q + 3'd1;
                    if (rc_d == n_q) begin
                        if (owner_q == PORT_LSB) begin
                            lsb_success_d = 1'b1;
                            lsb_value_d   = buf_d;
                        end else begin
                            if_success_d = 1'b1;
                            if_value_d   = buf_d;
                        end
                        state_d = DONE;
                    end
                end
                do_issue = bus.rdy;
            end

            WRITE: begin
                if (bus.rdy) begin
                    if (ic_q == n_q) begin
                        lsb_success_d = 1'b1;
                        state_d       = DONE;
                    end else begin
                        do_issue = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_issue && ic_d < n_d) begin
            io_stall = wr_op_d && (base_d >= IO_BASE) && bus.io_buffer_full;
            if (!io_stall) begin
                mem_a_d = base_d + {29'b0, ic_d};
                if (wr_op_d) begin
                    case (ic_d[1:0])
                        2'd0:    wr_byte = data_d[7:0];
                        2'd1:    wr_byte = data_d[15:8];
                        2'd2:    wr_byte = data_d[23:16];
                        default: wr_byte = data_d[31:24];
                    endcase
                    mem_wr_d   = 1'b1;
                    mem_dout_d = wr_byte;
                end else begin
                    a_vld_d = 1'b1;
                end
                ic_d = ic_d + 3'd1;
            end
        end

        // A flush kills reads outright, including one completing on this edge; stores always finish.
        if (bus.clr && (state_q == READ || state_q == DONE)) begin
            state_d       = IDLE;
            a_vld_d       = 1'b0;
            if_success_d  = 1'b0;
            lsb_success_d = 1'b0;
            if_value_d    = if_value_q;
            lsb_value_d   = lsb_value_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            base_q        <= 32'h0;
            n_q           <= 3'd0;
            ic_q          <= 3'd0;
            rc_q          <= 3'd0;
            a_vld_q       <= 1'b0;
            buf_q         <= 32'h0;
            owner_q       <= PORT_IF;
            last_q        <= PORT_IF;
            wr_op_q       <= 1'b0;
            data_q        <= 32'h0;
            mem_a_q       <= 32'h0;
            mem_dout_q    <= 8'h00;
            mem_wr_q      <= 1'b0;
            if_success_q  <= 1'b0;
            if_value_q    <= 32'h0;
            lsb_success_q <= 1'b0;
            lsb_value_q   <= 32'h0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            n_q           <= n_d;
            ic_q          <= ic_d;
            rc_q          <= rc_d;
            a_vld_q       <= a_vld_d;
            buf_q         <= buf_d;
            owner_q       <= owner_d;
            last_q        <= last_d;
            wr_op_q       <= wr_op_d;
            data_q        <= data_d;
            mem_a_q       <= mem_a_d;
            mem_dout_q    <= mem_dout_d;
            mem_wr_q      <= mem_wr_d;
            if_success_q  <= if_success_d;
            if_value_q    <= if_value_d;
            lsb_success_q <= lsb_success_d;
            lsb_value_q   <= lsb_value_d;
        end
    end

    assign bus.mem_a       = mem_a_q;
    assign bus.mem_dout    = mem_dout_q;
    assign bus.mem_wr      = mem_wr_q;
    assign bus.IF_success  = if_success_q;
    assign bus.IF_value    = if_value_q;
    assign bus.LSB_success = lsb_success_q;
    assign bus.LSB_value   = lsb_value_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a small RAM model answers reads, and every edge of
// each transaction is checked against hand-derived addresses, bytes and pulses.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_arbiter_if bus();

    mem_arbiter #(.IO_BASE(32'h30000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [0:1023];
    assign bus.mem_din = ram[bus.mem_a[9:0]];

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic lsb_req(input logic op, input logic [31:0] pc, input logic [2:0] len,
                           input logic [31:0] data);
        bus.LSB_op   = op;
        bus.LSB_pc   = pc;
        bus.LSB_len  = len;
        bus.LSB_data = data;
        bus.LSB_S    = 1'b1;
    endtask

    logic [31:0] sw_word;

    initial begin
        bus.rdy = 1'b1;
        bus.clr = 1'b0;
        bus.io_buffer_full = 1'b0;
        bus.IF_S = 1'b0;
        bus.IF_pc = 32'h0;
        bus.LSB_S = 1'b0;
        bus.LSB_op = 1'b0;
        bus.LSB_pc = 32'h0;
        bus.LSB_len = 3'd0;
        bus.LSB_data = 32'h0;
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[10'h100] = 8'h11; ram[10'h101] = 8'h22; ram[10'h102] = 8'h33; ram[10'h103] = 8'h44;
        ram[10'h200] = 8'hA5; ram[10'h201] = 8'h9C;
        ram[10'h300] = 8'h01; ram[10'h301] = 8'h02; ram[10'h302] = 8'h03; ram[10'h303] = 8'h04;

        // reset values
        step();
        step();
        chk("rst_mem_a", bus.mem_a, 32'h0);
        chk("rst_mem_dout", 32'(bus.mem_dout), 32'h0);
        chk("rst_mem_wr", 32'(bus.mem_wr), 32'h0);
        chk("rst_if_succ", 32'(bus.IF_success), 32'h0);
        chk("rst_lsb_succ", 32'(bus.LSB_success), 32'h0);
        chk("rst_if_val", bus.IF_value, 32'h0);
        chk("rst_lsb_val", bus.LSB_value, 32'h0);
        rst = 1'b0;

        // fetch only
        bus.IF_pc = 32'h100;
        bus.IF_S  = 1'b1;
        step();
        chk("fetch_a0", bus.mem_a, 32'h100);
        bus.IF_S = 1'b0;
        for (int k = 1; k < 4; k++) begin
            step();
            chk("fetch_a", bus.mem_a, 32'h100 + k);
            chk("fetch_early", 32'(bus.IF_success), 32'h0);
        end
        step();
        chk("fetch_succ", 32'(bus.IF_success), 32'h1);
        chk("fetch_val", bus.IF_value, 32'h44332211);
        step();
        chk("fetch_pulse", 32'(bus.IF_success), 32'h0);

        // tie straight after reset: LSB first, then IF after two idle edges
        do_reset();
        bus.IF_pc = 32'h100;
        bus.IF_S  = 1'b1;
        lsb_req(1'b0, 32'h200, 3'd1, 32'h0);
        step();
        chk("tie_lsb_a", bus.mem_a, 32'h200);
        bus.LSB_S = 1'b0;
        step();
        chk("tie_lbu_succ", 32'(bus.LSB_success), 32'h1);
        chk("tie_lbu_val", bus.LSB_value, 32'h000000A5);
        chk("tie_if_quiet", 32'(bus.IF_success), 32'h0);
        step();
        chk("tie_gap_a", bus.mem_a, 32'h200);
        chk("tie_lbu_pulse", 32'(bus.LSB_success), 32'h0);
        step();
        chk("tie_if_a", bus.mem_a, 32'h100);
        bus.IF_S = 1'b0;
        step(); step(); step(); step();
        chk("tie_if_succ", 32'(bus.IF_success), 32'h1);
        chk("tie_if_val", bus.IF_value, 32'h44332211);
        step();

        // SW of 0xDEADBEEF to 0x40
        sw_word = 32'hDEADBEEF;
        lsb_req(1'b1, 32'h40, 3'd4, sw_word);
        for (int k = 0; k < 4; k++) begin
            step();
            if (k == 0) bus.LSB_S = 1'b0;
            chk("sw_wr", 32'(bus.mem_wr), 32'h1);
            chk("sw_a", bus.mem_a, 32'h40 + k);
            chk("sw_dout", 32'(bus.mem_dout), 32'(sw_word[k*8 +: 8]));
            chk("sw_early", 32'(bus.LSB_success), 32'h0);
        end
        step();
        chk("sw_wr_end", 32'(bus.mem_wr), 32'h0);
        chk("sw_succ", 32'(bus.LSB_success), 32'h1);
        step();
        chk("sw_pulse", 32'(bus.LSB_success), 32'h0);

        // SB to IO with the sink full for three edges
        bus.io_buffer_full = 1'b1;
        lsb_req(1'b1, 32'h30000, 3'd1, 32'h0000005A);
        for (int k = 0; k < 3; k++) begin
            step();
            if (k == 0) bus.LSB_S = 1'b0;
            chk("io_stall_wr", 32'(bus.mem_wr), 32'h0);
        end
        bus.io_buffer_full = 1'b0;
        step();
        chk("io_wr", 32'(bus.mem_wr), 32'h1);
        chk("io_a", bus.mem_a, 32'h30000);
        chk("io_dout", 32'(bus.mem_dout), 32'h5A);
        chk("io_early", 32'(bus.LSB_success), 32'h0);
        step();
        chk("io_wr_end", 32'(bus.mem_wr), 32'h0);
        chk("io_succ", 32'(bus.LSB_success), 32'h1);
        step();

        // clr during LW after two bytes captured; IF picks up the bus next edge
        lsb_req(1'b0, 32'h300, 3'd4, 32'h0);
        step();
        chk("clrlw_a0", bus.mem_a, 32'h300);
        bus.LSB_S = 1'b0;
        step();
        step();
        bus.clr   = 1'b1;
        bus.IF_pc = 32'h100;
        bus.IF_S  = 1'b1;
        step();
        chk("clrlw_nosucc0", 32'(bus.LSB_success), 32'h0);
        bus.clr = 1'b0;
        step();
        chk("clrlw_if_a", bus.mem_a, 32'h100);
        chk("clrlw_nosucc1", 32'(bus.LSB_success), 32'h0);
        bus.IF_S = 1'b0;
        step();
        chk("clrlw_nosucc2", 32'(bus.LSB_success), 32'h0);
        step(); step(); step();
        chk("clrlw_if_succ", 32'(bus.IF_success), 32'h1);
        chk("clrlw_if_val", bus.IF_value, 32'h44332211);
        step();

        // clr during SH is ignored
        lsb_req(1'b1, 32'h50, 3'd2, 32'h0000CAFE);
        step();
        chk("clrsh_wr0", 32'(bus.mem_wr), 32'h1);
        chk("clrsh_a0", bus.mem_a, 32'h50);
        chk("clrsh_d0", 32'(bus.mem_dout), 32'hFE);
        bus.LSB_S = 1'b0;
        bus.clr   = 1'b1;
        step();
        chk("clrsh_wr1", 32'(bus.mem_wr), 32'h1);
        chk("clrsh_a1", bus.mem_a, 32'h51);
        chk("clrsh_d1", 32'(bus.mem_dout), 32'hCA);
        bus.clr = 1'b0;
        step();
        chk("clrsh_wr_end", 32'(bus.mem_wr), 32'h0);
        chk("clrsh_succ", 32'(bus.LSB_success), 32'h1);
        step();

        // rdy low for two edges mid-LW
        lsb_req(1'b0, 32'h300, 3'd4, 32'h0);
        step();
        chk("rdy_a0", bus.mem_a, 32'h300);
        bus.LSB_S = 1'b0;
        step();
        chk("rdy_a1", bus.mem_a, 32'h301);
        bus.rdy = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            chk("rdy_hold_a", bus.mem_a, 32'h301);
            chk("rdy_hold_wr", 32'(bus.mem_wr), 32'h0);
        end
        bus.rdy = 1'b1;
        step();
        chk("rdy_a2", bus.mem_a, 32'h302);
        chk("rdy_early0", 32'(bus.LSB_success), 32'h0);
        step();
        chk("rdy_a3", bus.mem_a, 32'h303);
        chk("rdy_early1", 32'(bus.LSB_success), 32'h0);
        step();
        chk("rdy_succ", 32'(bus.LSB_success), 32'h1);
        chk("rdy_val", bus.LSB_value, 32'h04030201);
        step();

        // LBU after a full word: upper bytes must come back zero
        lsb_req(1'b0, 32'h201, 3'd1, 32'h0);
        step();
        bus.LSB_S = 1'b0;
        step();
        chk("lbu_succ", 32'(bus.LSB_success), 32'h1);
        chk("lbu_zext", bus.LSB_value, 32'h0000009C);
        step();

        // tie after an LSB grant: IF first, LSB two edges after IF completes
        bus.IF_pc = 32'h100;
        bus.IF_S  = 1'b1;
        lsb_req(1'b0, 32'h200, 3'd1, 32'h0);
        step();
        chk("rr_if_a", bus.mem_a, 32'h100);
        bus.IF_S = 1'b0;
        step(); step(); step(); step();
        chk("rr_if_succ", 32'(bus.IF_success), 32'h1);
        step();
        step();
        chk("rr_lsb_a", bus.mem_a, 32'h200);
        bus.LSB_S = 1'b0;
        step();
        chk("rr_lsb_succ", 32'(bus.LSB_success), 32'h1);
        chk("rr_lsb_val", bus.LSB_value, 32'h000000A5);
        step();

        // reset in the middle of a store
        lsb_req(1'b1, 32'h60, 3'd4, 32'h11223344);
        step();
        chk("rstmid_wr0", 32'(bus.mem_wr), 32'h1);
        rst = 1'b1;
        bus.LSB_S = 1'b0;
        step();
        chk("rstmid_wr", 32'(bus.mem_wr), 32'h0);
        chk("rstmid_a", bus.mem_a, 32'h0);
        chk("rstmid_dout", 32'(bus.mem_dout), 32'h0);
        chk("rstmid_val", bus.LSB_value, 32'h0);
        rst = 1'b0;
        step();
        chk("rstmid_idle_wr", 32'(bus.mem_wr), 32'h0);
        chk("rstmid_nosucc", 32'(bus.LSB_success), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
